// File: rtl/alu_sequencer.sv
// alu_sequencer: clocked initiator for a combinational 32-bit ALU.
// Registers one op, waits a per-class settle time, then holds the response.
module alu_sequencer #(
    parameter int WIDTH        = 32,
    parameter int LOGIC_SETTLE = 2,
    parameter int ARITH_SETTLE = 10,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_XOR  = 3'd2;
    localparam logic [2:0] C_SLT  = 3'd3;
    localparam logic [2:0] C_AND  = 3'd4;
    localparam logic [2:0] C_NAND = 3'd5;
    localparam logic [2:0] C_NOR  = 3'd6;
    localparam logic [2:0] C_OR   = 3'd7;

    // A settle time of zero would never complete; clamp to one cycle.
    localparam int L_N   = (LOGIC_SETTLE < 1) ? 1 : LOGIC_SETTLE;
    localparam int A_N   = (ARITH_SETTLE < 1) ? 1 : ARITH_SETTLE;
    localparam int MAX_N = (L_N > A_N) ? L_N : A_N;
    localparam int CW    = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_cmd;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic             r_rsp_zero;
    logic             r_rsp_ovf;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic             w_done;
    logic             w_hs;
    logic             w_req_arith;
    logic             w_cur_arith;
    logic [CW-1:0]    w_load;

    // Classify commands: arithmetic ops use the long ripple settle time.
    always_comb begin
        w_req_arith = 1'b0;
        w_cur_arith = 1'b0;
        case (req_cmd)
            C_ADD, C_SUB, C_SLT:           w_req_arith = 1'b1;
            C_XOR, C_AND, C_NAND, C_NOR,
            C_OR:                          w_req_arith = 1'b0;
            default:                       w_req_arith = 1'b0;
        endcase
        case (r_alu_cmd)
            C_ADD, C_SUB, C_SLT:           w_cur_arith = 1'b1;
            default:                       w_cur_arith = 1'b0;
        endcase
    end

    assign w_load   = w_req_arith ? CW'(A_N) : CW'(L_N);
    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_done   = (r_state == S_SETTLE) && (r_cnt == CW'(1));
    assign w_hs     = (r_state == S_RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic: one op in flight, IDLE -> SETTLE -> RESP -> IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETTLE;
            S_SETTLE: if (w_done)   w_next = S_RESP;
            S_RESP:   if (w_hs)     w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            S_IDLE:   req_ready = 1'b1;
            S_SETTLE: busy      = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                busy      = 1'b1;
            end
            default:  req_ready = 1'b0;
        endcase
    end

    // ALU drive registers: loaded on accept, held afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cmd <= '0;
        end else if (w_accept) begin
            r_alu_a   <= req_a;
            r_alu_b   <= req_b;
            r_alu_cmd <= req_cmd;
        end
    end

    // Settle counter: loaded with N on accept, counts down to the capture edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_load;
        end else if (r_state == S_SETTLE) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Response capture; logic ops carry no meaningful carry/overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else if (w_done) begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_carry  <= w_cur_arith & alu_carryout;
            r_rsp_ovf    <= w_cur_arith & alu_overflow;
        end
    end

    // Completed-op counter advances on each response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_op_count <= '0;
        else if (w_hs) r_op_count <= r_op_count + CNT_W'(1);
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_cmd      = r_alu_cmd;
    assign rsp_result   = r_rsp_result;
    assign rsp_carryout = r_rsp_carry;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_ovf;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer.
// A behavioural 32-bit ALU sits on the alu_* ports.
module tb_alu_sequencer;

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_XOR  = 3'd2;
    localparam logic [2:0] C_SLT  = 3'd3;
    localparam logic [2:0] C_AND  = 3'd4;
    localparam logic [2:0] C_NAND = 3'd5;
    localparam logic [2:0] C_NOR  = 3'd6;
    localparam logic [2:0] C_OR   = 3'd7;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_cmd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        busy;
    logic [1:0]  op_count;

    int n_cmp = 0;
    int n_bad = 0;

    alu_sequencer #(
        .WIDTH(32), .LOGIC_SETTLE(2), .ARITH_SETTLE(10), .CNT_W(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; logic ops drive junk 1s on carry/overflow.
    logic [32:0] t_sum;
    logic [32:0] t_dif;
    logic        t_sov;
    always_comb begin
        t_sum        = {1'b0, alu_a} + {1'b0, alu_b};
        t_dif        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        t_sov        = (alu_a[31] != alu_b[31]) && (t_dif[31] != alu_a[31]);
        alu_result   = '0;
        alu_carryout = 1'b1;
        alu_overflow = 1'b1;
        case (alu_cmd)
            C_ADD: begin
                alu_result   = t_sum[31:0];
                alu_carryout = t_sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) &&
                               (t_sum[31] != alu_a[31]);
            end
            C_SUB: begin
                alu_result   = t_dif[31:0];
                alu_carryout = t_dif[32];
                alu_overflow = t_sov;
            end
            C_SLT: begin
                alu_result   = {31'd0, t_dif[31] ^ t_sov};
                alu_carryout = t_dif[32];
                alu_overflow = t_sov;
            end
            C_XOR:  alu_result = alu_a ^ alu_b;
            C_AND:  alu_result = alu_a & alu_b;
            C_NAND: alu_result = ~(alu_a & alu_b);
            C_NOR:  alu_result = ~(alu_a | alu_b);
            C_OR:   alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request in IDLE, count edges until rsp_valid.
    task automatic issue(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        req_cmd   = c;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_a"},  alu_a, 32'd0);
        chk({tag, "_alu_b"},  alu_b, 32'd0);
        chk({tag, "_alu_cmd"}, {29'd0, alu_cmd}, 32'd0);
        chk({tag, "_rsp_res"}, rsp_result, 32'd0);
        chk({tag, "_rsp_flg"},
            {28'd0, rsp_valid, rsp_carryout, rsp_zero, rsp_overflow},
            32'd0);
        chk({tag, "_busy_cnt"}, {29'd0, busy, op_count}, 32'd0);
    endtask

    int lat;
    int seen;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cmd   = '0;
        #12;
        chk_all_zero("por");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("por_ready", {31'd0, req_ready}, 32'd1);

        // ADD with signed overflow, 10-cycle settle
        issue(C_ADD, 32'h7000_0000, 32'h2000_0000, lat);
        chk("add_lat", lat, 10);
        chk("add_res", rsp_result, 32'h9000_0000);
        chk("add_flg", {29'd0, rsp_carryout, rsp_overflow, rsp_zero},
            32'b010);
        chk("add_rdy", {31'd0, req_ready}, 32'd0);
        complete();
        chk("add_cnt", {30'd0, op_count}, 32'd1);
        chk("add_hold_a", alu_a, 32'h7000_0000);

        // AND, 2-cycle settle, carry/overflow masked
        issue(C_AND, 32'haaaa_aaaa, 32'hcccc_cccc, lat);
        chk("and_lat", lat, 2);
        chk("and_res", rsp_result, 32'h8888_8888);
        chk("and_flg", {29'd0, rsp_carryout, rsp_overflow, rsp_zero},
            32'b000);
        complete();
        chk("and_cnt", {30'd0, op_count}, 32'd2);

        // SUB equal operands, consumer stalls 5 cycles
        issue(C_SUB, 32'h1234_abcd, 32'h1234_abcd, lat);
        chk("sub_lat", lat, 10);
        req_cmd   = C_OR;
        req_a     = 32'h0000_00f0;
        req_b     = 32'h0000_000f;
        req_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 ||
                rsp_zero !== 1'b1 || rsp_carryout !== 1'b1 ||
                req_ready !== 1'b0 || op_count !== 2'd2)
                seen++;
        end
        chk("sub_stall", seen, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("sub_cnt", {30'd0, op_count}, 32'd3);
        chk("sub_post", {29'd0, rsp_valid, req_ready, busy}, 32'b010);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("or_acc", {30'd0, busy, req_ready}, 32'b10);
        chk("or_alu", alu_a, 32'h0000_00f0);
        seen = 0;
        while (!rsp_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("or_lat", seen, 2);
        chk("or_res", rsp_result, 32'h0000_00ff);

        // Reset asserted while a response is held
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid");
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel", {29'd0, req_ready, busy, rsp_valid}, 32'b100);

        // SLT aborted at settle cycle 4, then rerun
        req_cmd   = C_SLT;
        req_a     = 32'h8000_0000;
        req_b     = 32'hffff_ffff;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("slt_busy", {30'd0, busy, rsp_valid}, 32'b10);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        chk("slt_abort", {29'd0, busy, op_count}, 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("slt_norsp", seen, 0);
        issue(C_SLT, 32'h8000_0000, 32'hffff_ffff, lat);
        chk("slt_lat", lat, 10);
        chk("slt_res", rsp_result, 32'h0000_0001);
        complete();

        // Counter wraps: five ops on a fresh reset with CNT_W=2
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        issue(C_XOR,  32'hffff_0000, 32'h0f0f_0f0f, lat);
        chk("xor_res", rsp_result, 32'hf0f0_0f0f);
        complete();
        issue(C_NAND, 32'hffff_ffff, 32'hffff_ffff, lat);
        chk("nand_z", {31'd0, rsp_zero}, 32'd1);
        complete();
        issue(C_NOR,  32'h0000_0000, 32'h0000_0000, lat);
        chk("nor_res", rsp_result, 32'hffff_ffff);
        complete();
        issue(C_ADD,  32'hffff_ffff, 32'h0000_0001, lat);
        chk("add2_flg", {29'd0, rsp_carryout, rsp_overflow, rsp_zero},
            32'b101);
        complete();
        issue(C_OR,   32'h1, 32'h2, lat);
        complete();
        chk("wrap_cnt", {30'd0, op_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
